// File: rtl/boom_sequencer_if.sv
// Key inputs and display outputs of the boom sequencer, bundled for port connection.
// master: drives start/pause and observes the display; slave: the sequencer itself.
// Only the clock and reset stay outside the bundle.
interface boom_sequencer_if;
  logic       start;
  logic       pause;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       boom;
  logic       led;
  logic       step;
  logic       done;
  logic [2:0] state;

  modport master (
    output start, pause,
    input  ones, tens, boom, led, step, done, state
  );

  modport slave (
    input  start, pause,
    output ones, tens, boom, led, step, done, state
  );
endinterface

// File: rtl/boom_sequencer.sv
// boom_sequencer: start/pause/boom/done game FSM stepping a two-digit BCD count every TICK_DIV cycles.
// All outputs registered; a key edge sampled on one clock edge changes state on the following edge.
// Optional macro BOOM_DIGIT_EN: values containing the digit BOOM_N also boom (besides multiples).
module boom_sequencer #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int MAX_COUNT = 15,
  parameter int BOOM_N    = 7,
  parameter int BOOM_HOLD = 2
) (
  input logic             CLOCK_50,
  input logic             rst,
  boom_sequencer_if.slave bus
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (BOOM_HOLD > 0) ? $clog2(BOOM_HOLD + 1) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(BOOM_HOLD);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [3:0]    MOD_LAST  = 4'(BOOM_N - 1);
  localparam logic [3:0]    MAX_ONES  = 4'(MAX_COUNT % 10);
  localparam logic [3:0]    MAX_TENS  = 4'(MAX_COUNT / 10);
`ifdef BOOM_DIGIT_EN
  localparam logic [3:0]    BOOM_DIGIT = 4'(BOOM_N);
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    BOOM   = 3'd2,
    PAUSED = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t        cur;
  logic [DW-1:0] div;
  logic [HW-1:0] hold;
  logic [3:0]    mod;
  logic [3:0]    ones;
  logic [3:0]    tens;
  logic          boom_q;
  logic          step_q;
  logic          done_q;
  logic          start_prev;
  logic          pause_prev;

  logic          start_edge;
  logic          pause_edge;
  logic          tick;
  logic [3:0]    inc_ones;
  logic [3:0]    inc_tens;
  logic [3:0]    inc_mod;
  logic          inc_boom;
  logic          inc_max;
  logic          at_max;

  assign bus.ones  = ones;
  assign bus.tens  = tens;
  assign bus.boom  = boom_q;
  assign bus.led   = boom_q;
  assign bus.step  = step_q;
  assign bus.done  = done_q;
  assign bus.state = cur;

  // Key edges, divider terminal count and the candidate next count value.
  always_comb begin
    start_edge = bus.start & ~start_prev;
    pause_edge = bus.pause & ~pause_prev;
    tick       = (div == DIV_LAST);
    if (ones == 4'd9) begin
      inc_ones = 4'd0;
      inc_tens = tens + 4'd1;
    end else begin
      inc_ones = ones + 4'd1;
      inc_tens = tens;
    end
    inc_mod = (mod == MOD_LAST) ? 4'd0 : mod + 4'd1;
    // The incremented value is never zero, so only the remainder wrap matters.
`ifdef BOOM_DIGIT_EN
    inc_boom = (inc_mod == 4'd0) || (inc_ones == BOOM_DIGIT) || (inc_tens == BOOM_DIGIT);
`else
    inc_boom = (inc_mod == 4'd0);
`endif
    inc_max = (inc_ones == MAX_ONES) && (inc_tens == MAX_TENS);
    at_max  = (ones == MAX_ONES) && (tens == MAX_TENS);
  end

  // Previous key samples for rising-edge detection.
  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      start_prev <= 1'b0;
      pause_prev <= 1'b0;
    end else begin
      start_prev <= bus.start;
      pause_prev <= bus.pause;
    end
  end

  // Game FSM with divider, BCD count, remainder, boom hold and registered flags.
  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      cur    <= IDLE;
      div    <= '0;
      hold   <= '0;
      mod    <= 4'd0;
      ones   <= 4'd0;
      tens   <= 4'd0;
      boom_q <= 1'b0;
      step_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      step_q <= 1'b0;
      case (cur)
        IDLE: begin
          div <= '0;
          if (start_edge) begin
            cur  <= RUN;
            ones <= 4'd0;
            tens <= 4'd0;
            mod  <= 4'd0;
          end
        end
        RUN: begin
          // Pause beats a coincident tick; the divider stays where it is.
          if (pause_edge) begin
            cur <= PAUSED;
          end else if (tick) begin
            div    <= '0;
            ones   <= inc_ones;
            tens   <= inc_tens;
            mod    <= inc_mod;
            step_q <= 1'b1;
            if (inc_boom) begin
              cur    <= BOOM;
              hold   <= HOLD_INIT;
              boom_q <= 1'b1;
            end else if (inc_max) begin
              cur    <= DONE;
              done_q <= 1'b1;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        BOOM: begin
          // Count stalls; leave after BOOM_HOLD full tick periods.
          if (tick) begin
            div <= '0;
            if (hold == HOLD_ONE) begin
              hold   <= '0;
              boom_q <= 1'b0;
              if (at_max) begin
                cur    <= DONE;
                done_q <= 1'b1;
              end else begin
                cur <= RUN;
              end
            end else begin
              hold <= hold - 1'b1;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        PAUSED: begin
          // Divider preserved so the interrupted tick period resumes.
          if (start_edge) begin
            cur <= RUN;
          end
        end
        DONE: begin
          div <= '0;
          if (start_edge) begin
            cur    <= RUN;
            done_q <= 1'b0;
            ones   <= 4'd0;
            tens   <= 4'd0;
            mod    <= 4'd0;
          end
        end
        default: begin
          cur <= IDLE;
        end
      endcase
    end
  end

endmodule
